// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: mono 24-bit sample to I2S serializer.
// One sample per 64-BCLK frame (two 32-bit slots). The same word is sent on the left
// and right slots. A one-entry input buffer decouples the FIR strobe from the frame
// boundary. Sticky flags report when a sample was overwritten (overrun) or when a
// frame started with no fresh sample (underrun).
module audio_i2s_tx #(
    parameter int unsigned BCLK_HALF = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] sample_in,
    input  logic        sample_valid,
    input  logic        clr_flags,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_start,
    output logic        overrun,
    output logic        underrun
);

    // BCLK_HALF >= 2 keeps the prescaler at least one bit wide and gives the codec
    // a full clk cycle of setup before each rise.
    localparam int unsigned DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF - 1);

    if (BCLK_HALF < 2) begin : g_bad_param
        $error("audio_i2s_tx: BCLK_HALF must be at least 2");
    end

    // Prescaler and BCLK phase.
    logic [DivW-1:0] div_cnt;
    logic            div_tc;
    logic            fall_ev;

    // Slot counter: 0..31 left slot, 32..63 right slot.
    logic [5:0]      k;
    logic [5:0]      k_next;
    logic [4:0]      slot_pos;
    logic [4:0]      bit_idx;
    logic            sdata_next;

    // Sample storage.
    logic [23:0]     active;
    logic [23:0]     pending;
    logic            full;
    logic            load;

    logic [23:0]     active_d;
    logic [23:0]     pending_d;
    logic            full_d;
    logic            overrun_d;
    logic            underrun_d;

    assign div_tc  = (div_cnt == DivLast);
    // bclk is about to toggle from 1 to 0.
    assign fall_ev = div_tc & bclk;
    assign k_next  = k + 6'd1;
    // Frame boundary: the fall event that wraps the slot counter to 0.
    assign load    = fall_ev & (k_next == 6'd0);

    assign frame_start = load;

    // Bit position within the slot that the next fall will launch.
    assign slot_pos = k_next[4:0];
    assign bit_idx  = 5'd24 - slot_pos;

    // Slot bit 0 is the I2S one-BCLK delay, bits 1..24 carry the word MSB first,
    // bits 25..31 are padding zeros.
    always_comb begin
        sdata_next = 1'b0;
        if (slot_pos >= 5'd1 && slot_pos <= 5'd24) begin
            sdata_next = active[bit_idx];
        end
    end

    // Prescaler: divide clk down to the half-period of BCLK and toggle bclk on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DivW'(1);
        end
    end

    // Slot counter and serial outputs, all launched on the bclk fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k     <= 6'd63;
            lrclk <= 1'b0;
            sdata <= 1'b0;
        end else if (fall_ev) begin
            k     <= k_next;
            lrclk <= k_next[5];
            sdata <= sdata_next;
        end
    end

    // Next-state of the input buffer, the active word and the sticky flags.
    always_comb begin
        active_d   = active;
        pending_d  = pending;
        full_d     = full;
        overrun_d  = overrun;
        underrun_d = underrun;

        // Clear first so that a set condition in the same cycle wins.
        if (clr_flags) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end

        // The load sees the buffer as it was before this cycle's strobe.
        if (load) begin
            if (full) begin
                active_d = pending;
                full_d   = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // A strobe on a load cycle refills the slot the load just drained, so it
        // is never an overrun.
        if (sample_valid) begin
            if (full && !load) begin
                overrun_d = 1'b1;
            end
            pending_d = sample_in;
            full_d    = 1'b1;
        end
    end

    // Sample buffer and sticky flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active   <= '0;
            pending  <= '0;
            full     <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            active   <= active_d;
            pending  <= pending_d;
            full     <= full_d;
            overrun  <= overrun_d;
            underrun <= underrun_d;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: scoreboard bench for audio_i2s_tx.
// The stimulus process drives strobes edge by edge and keeps a reference model of the
// buffer semantics; at every frame boundary it pushes the word that frame must carry.
// A monitor reassembles frames from bclk rises and checks them, plus the per-cycle
// bclk, frame_start and flag values, against the model.
module tb_audio_i2s_tx;

    localparam int unsigned BH    = 2;
    localparam int          FRAME = 128 * BH;
    localparam int          FIRST = 2 * BH;

    logic        clk;
    logic        reset;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic        clr_flags;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        frame_start;
    logic        overrun;
    logic        underrun;

    audio_i2s_tx #(
        .BCLK_HALF(BH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .clr_flags   (clr_flags),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .overrun     (overrun),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          edge_n;          // clk rising edges since reset release
    logic [23:0] m_active;
    logic [23:0] m_pending;
    bit          m_full;
    bit          m_ovr;
    bit          m_udr;
    logic [23:0] sb[$];           // words the upcoming frames must carry
    int          frames_expected;
    int          frames_checked;

    // Frames begin every 128*BH clocks, the first one 2*BH clocks after release.
    function automatic bit is_load(input int n);
        return (n >= FIRST) && (((n - FIRST) % FRAME) == 0);
    endfunction

    function automatic int load_edge(input int f);
        return FIRST + f * FRAME;
    endfunction

    task automatic model_reset();
        edge_n    = 0;
        m_active  = '0;
        m_pending = '0;
        m_full    = 1'b0;
        m_ovr     = 1'b0;
        m_udr     = 1'b0;
        frames_expected -= sb.size();
        sb.delete();
    endtask

    task automatic model_edge(input bit v, input logic [23:0] d, input bit c);
        bit ld;
        bit was_full;
        edge_n++;
        ld       = is_load(edge_n);
        was_full = m_full;
        if (c) begin
            m_ovr = 1'b0;
            m_udr = 1'b0;
        end
        if (ld) begin
            if (was_full) begin
                m_active = m_pending;
                m_full   = 1'b0;
            end else begin
                m_udr = 1'b1;
            end
            sb.push_back(m_active);
            frames_expected++;
        end
        if (v) begin
            if (was_full && !ld) m_ovr = 1'b1;
            m_pending = d;
            m_full    = 1'b1;
        end
    endtask

    // Drive one clk edge's worth of inputs, then update the model for that edge.
    task automatic edge_step(input bit v, input logic [23:0] d, input bit c);
        sample_valid = v;
        sample_in    = d;
        clr_flags    = c;
        @(posedge clk);
        model_edge(v, d, c);
        #1;
        sample_valid = 1'b0;
        clr_flags    = 1'b0;
    endtask

    task automatic goto(input int t);
        while (edge_n < t) edge_step(1'b0, 24'h0, 1'b0);
    endtask

    task automatic random_until(input int t);
        while (edge_n < t) begin
            edge_step($urandom_range(0, 99) == 0, 24'($urandom),
                      $urandom_range(0, 299) == 0);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_bclk;
    int          rises;
    logic [63:0] lr_acc;
    logic [63:0] sd_acc;

    always @(negedge clk) begin
        if (reset) begin
            prev_bclk = 1'b0;
            rises     = 0;
            lr_acc    = '0;
            sd_acc    = '0;
        end else begin
            check("bclk", bclk, 64'((edge_n / BH) % 2));
            check("frame_start", frame_start, is_load(edge_n + 1));
            check("overrun", overrun, m_ovr);
            check("underrun", underrun, m_udr);
            if (bclk && !prev_bclk) begin
                rises++;
                // The first rise after reset precedes slot 0 and carries no data.
                if (rises >= 2) begin
                    lr_acc = {lr_acc[62:0], lrclk};
                    sd_acc = {sd_acc[62:0], sdata};
                    if (((rises - 2) % 64) == 63) begin
                        if (sb.size() == 0) begin
                            check("frame_queue_empty", 64'(sb.size()), 64'd1);
                        end else begin
                            logic [23:0] w;
                            w = sb.pop_front();
                            check("lrclk_frame", lr_acc, {32'h0, 32'hFFFF_FFFF});
                            check("left_slot", sd_acc[63:32], {32'h0, 1'b0, w, 7'h0});
                            check("right_slot", sd_acc[31:0], {32'h0, 1'b0, w, 7'h0});
                            frames_checked++;
                        end
                    end
                end
            end
            prev_bclk = bclk;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        frames_expected = 0;
        frames_checked  = 0;
        reset           = 1'b1;
        sample_in       = '0;
        sample_valid    = 1'b0;
        clr_flags       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_bclk", bclk, 0);
        check("reset_lrclk", lrclk, 0);
        check("reset_sdata", sdata, 0);
        check("reset_flags", {overrun, underrun}, 0);
        reset = 1'b0;

        // Basic frame: sample ready before the first frame boundary.
        goto(1);
        edge_step(1'b1, 24'h800001, 1'b0);

        // Frame 1 repeats it with an underrun; clear, then two strobes overrun.
        goto(load_edge(1) + 10);
        edge_step(1'b0, 24'h0, 1'b1);
        goto(load_edge(1) + 20);
        edge_step(1'b1, 24'h123456, 1'b0);
        goto(load_edge(1) + 40);
        edge_step(1'b1, 24'hABCDEF, 1'b0);

        // Frame 2: clear, fill buffer, then strobe exactly on the frame 3 boundary.
        goto(load_edge(2) + 10);
        edge_step(1'b0, 24'h0, 1'b1);
        goto(load_edge(2) + 30);
        edge_step(1'b1, 24'h7FFFFF, 1'b0);
        goto(load_edge(3) - 1);
        edge_step(1'b1, 24'h00000F, 1'b0);

        // Frame 4: overrun in the same cycle as clr_flags must leave overrun set.
        goto(load_edge(4) + 10);
        edge_step(1'b0, 24'h0, 1'b1);
        goto(load_edge(4) + 20);
        edge_step(1'b1, 24'h13579B, 1'b0);
        goto(load_edge(4) + 40);
        edge_step(1'b1, 24'h2468AC, 1'b1);

        // Randomized traffic, then reset in the middle of the right slot (k = 40).
        random_until(load_edge(11) + 40 * 2 * BH + 1);
        reset = 1'b1;
        #1;
        check("midreset_bclk", bclk, 0);
        check("midreset_lrclk", lrclk, 0);
        check("midreset_sdata", sdata, 0);
        check("midreset_frame_start", frame_start, 0);
        check("midreset_overrun", overrun, 0);
        check("midreset_underrun", underrun, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        random_until(load_edge(2) - 1);
        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check("frames_checked", 64'(frames_checked), 64'(frames_expected));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
